// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: forwarding muxes, ALU, beq/jump
// resolution, the M-stage pipeline register and a taken-transfer counter.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [31:0] TakenCountM
);

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluSlt = 3'b101
  } aluOp_e;

  logic [31:0] srcAE;
  logic [31:0] writeDataE;
  logic [31:0] srcBE;
  logic [31:0] aluResultE;
  logic        zeroE;

  logic        regWrite_q,   regWrite_d;
  logic        memWrite_q,   memWrite_d;
  logic [1:0]  resultSrc_q,  resultSrc_d;
  logic [4:0]  rd_q,         rd_d;
  logic [31:0] aluResult_q,  aluResult_d;
  logic [31:0] writeData_q,  writeData_d;
  logic [31:0] pcPlus4_q,    pcPlus4_d;
  logic [31:0] takenCount_q, takenCount_d;

  // The M-stage source is this block's own registered result, i.e. the
  // instruction one ahead, which gives zero-bubble ALU-to-ALU forwarding.
  always_comb begin
    srcAE = RD1_E;
    case (ForwardAE)
      2'b01:   srcAE = ResultW;
      2'b10:   srcAE = aluResult_q;
      default: srcAE = RD1_E;
    endcase
  end

  always_comb begin
    writeDataE = RD2_E;
    case (ForwardBE)
      2'b01:   writeDataE = ResultW;
      2'b10:   writeDataE = aluResult_q;
      default: writeDataE = RD2_E;
    endcase
  end

  assign srcBE = ALUSrcE ? Imm_Ext_E : writeDataE;

  always_comb begin
    aluResultE = 32'd0;
    case (aluOp_e'(ALUControlE))
      AluAdd:  aluResultE = srcAE + srcBE;
      AluSub:  aluResultE = srcAE - srcBE;
      AluAnd:  aluResultE = srcAE & srcBE;
      AluOr:   aluResultE = srcAE | srcBE;
      AluXor:  aluResultE = srcAE ^ srcBE;
      AluSlt:  aluResultE = ($signed(srcAE) < $signed(srcBE)) ? 32'd1 : 32'd0;
      default: aluResultE = 32'd0;
    endcase
  end

  // Only beq exists, so "taken" is just a zero result from the subtract.
  assign zeroE     = (aluResultE == 32'd0);
  assign PCSrcE    = (BranchE & zeroE) | JumpE;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_comb begin
    regWrite_d   = RegWriteE;
    memWrite_d   = MemWriteE;
    resultSrc_d  = ResultSrcE;
    rd_d         = RD_E;
    aluResult_d  = aluResultE;
    writeData_d  = writeDataE;
    pcPlus4_d    = PCPlus4E;
    takenCount_d = takenCount_q;
    if (PCSrcE) begin
      takenCount_d = takenCount_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite_q   <= 1'b0;
      memWrite_q   <= 1'b0;
      resultSrc_q  <= 2'b00;
      rd_q         <= 5'd0;
      aluResult_q  <= 32'd0;
      writeData_q  <= 32'd0;
      pcPlus4_q    <= 32'd0;
      takenCount_q <= 32'd0;
    end else begin
      regWrite_q   <= regWrite_d;
      memWrite_q   <= memWrite_d;
      resultSrc_q  <= resultSrc_d;
      rd_q         <= rd_d;
      aluResult_q  <= aluResult_d;
      writeData_q  <= writeData_d;
      pcPlus4_q    <= pcPlus4_d;
      takenCount_q <= takenCount_d;
    end
  end

  assign RegWriteM   = regWrite_q;
  assign MemWriteM   = memWrite_q;
  assign ResultSrcM  = resultSrc_q;
  assign RD_M        = rd_q;
  assign ALUResultM  = aluResult_q;
  assign WriteDataM  = writeData_q;
  assign PCPlus4M    = pcPlus4_q;
  assign TakenCountM = takenCount_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases from the stage's rules
// plus randomized instructions checked against a behavioural pipeline model.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, TakenCountM;

  int total = 0;
  int bad   = 0;

  // Model of what the M-stage register should be holding right now.
  logic        mRegWrite, mMemWrite;
  logic [1:0]  mResultSrc;
  logic [4:0]  mRd;
  logic [31:0] mAlu, mWriteData, mPcPlus4, mCount;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .TakenCountM(TakenCountM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] refFwd(input logic [1:0] sel, input logic [31:0] reg_v, input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return reg_v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mRegWrite = 1'b0; mMemWrite = 1'b0; mResultSrc = 2'b00; mRd = 5'd0;
    mAlu = 32'd0; mWriteData = 32'd0; mPcPlus4 = 32'd0; mCount = 32'd0;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".RegWriteM"},   32'(RegWriteM),  32'(mRegWrite));
    checkOutput({tag, ".MemWriteM"},   32'(MemWriteM),  32'(mMemWrite));
    checkOutput({tag, ".ResultSrcM"},  32'(ResultSrcM), 32'(mResultSrc));
    checkOutput({tag, ".RD_M"},        32'(RD_M),       32'(mRd));
    checkOutput({tag, ".ALUResultM"},  ALUResultM,      mAlu);
    checkOutput({tag, ".WriteDataM"},  WriteDataM,      mWriteData);
    checkOutput({tag, ".PCPlus4M"},    PCPlus4M,        mPcPlus4);
    checkOutput({tag, ".TakenCountM"}, TakenCountM,     mCount);
  endtask

  // Drives one E-stage instruction, checks the same-cycle outputs, lets one
  // edge pass, advances the model and checks the whole M-stage register.
  task automatic applyStimulus(
    input string tag,
    input logic rw, input logic as, input logic mw, input logic br, input logic jp,
    input logic [1:0] rs, input logic [2:0] op,
    input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
    input logic [31:0] pc, input logic [31:0] pc4, input logic [4:0] rd,
    input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] resw);
    logic [31:0] a, wd, b, res, target;
    logic taken;
    RegWriteE = rw; ALUSrcE = as; MemWriteE = mw; BranchE = br; JumpE = jp;
    ResultSrcE = rs; ALUControlE = op; RD1_E = rd1; RD2_E = rd2;
    Imm_Ext_E = imm; PCE = pc; PCPlus4E = pc4; RD_E = rd;
    ForwardAE = fa; ForwardBE = fb; ResultW = resw;
    a      = refFwd(fa, rd1, resw, mAlu);
    wd     = refFwd(fb, rd2, resw, mAlu);
    b      = as ? imm : wd;
    res    = refAlu(op, a, b);
    taken  = (br && (res == 32'd0)) || jp;
    target = pc + imm;
    #1;
    checkOutput({tag, ".PCSrcE"},    32'(PCSrcE), 32'(taken));
    checkOutput({tag, ".PCTargetE"}, PCTargetE,   target);
    @(posedge clk);
    #1;
    mRegWrite = rw; mMemWrite = mw; mResultSrc = rs; mRd = rd;
    mAlu = res; mWriteData = wd; mPcPlus4 = pc4;
    if (taken) mCount = mCount + 32'd1;
    checkRegs(tag);
  endtask

  initial begin
    rst = 1'b0;
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
    ResultSrcE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    PCE = 0; PCPlus4E = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    modelReset();

    // Reset, then a first add
    #2 rst = 1'b1;
    #1 checkRegs("reset");
    @(posedge clk); @(posedge clk);
    #1 checkRegs("resetHeld");
    rst = 1'b0;
    applyStimulus("add5p7", 1, 0, 0, 0, 0, 2'd0, 3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd4, 5'd3, 2'd0, 2'd0, 32'd0);
    checkOutput("add5p7.result", ALUResultM, 32'd12);
    checkOutput("add5p7.rd", 32'(RD_M), 32'd3);

    // ALU sweep at the sign boundary
    applyStimulus("sub", 1, 0, 0, 0, 0, 2'd0, 3'd1, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 32'd4, 5'd1, 2'd0, 2'd0, 32'd0);
    checkOutput("sub.const", ALUResultM, 32'h7FFF_FFFF);
    applyStimulus("slt", 1, 0, 0, 0, 0, 2'd0, 3'd5, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 32'd4, 5'd1, 2'd0, 2'd0, 32'd0);
    checkOutput("slt.const", ALUResultM, 32'd1);
    applyStimulus("xor", 1, 0, 0, 0, 0, 2'd0, 3'd4, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 32'd4, 5'd1, 2'd0, 2'd0, 32'd0);
    checkOutput("xor.const", ALUResultM, 32'h8000_0001);
    applyStimulus("addWrap", 1, 0, 0, 0, 0, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd4, 5'd1, 2'd0, 2'd0, 32'd0);
    checkOutput("addWrap.const", ALUResultM, 32'd0);
    applyStimulus("op110", 1, 0, 0, 0, 0, 2'd0, 3'd6, 32'h1234_5678, 32'd9, 32'd0, 32'd0, 32'd4, 5'd1, 2'd0, 2'd0, 32'd0);
    checkOutput("op110.const", ALUResultM, 32'd0);

    // Forwarding from M and W
    applyStimulus("fwdPrep", 1, 0, 0, 0, 0, 2'd0, 3'd0, 32'h10, 32'd0, 32'd0, 32'd0, 32'd4, 5'd2, 2'd0, 2'd0, 32'd0);
    applyStimulus("fwdAdd", 1, 0, 0, 0, 0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 5'd2, 2'd2, 2'd1, 32'h20);
    checkOutput("fwdAdd.result", ALUResultM, 32'h30);
    checkOutput("fwdAdd.wdata", WriteDataM, 32'h20);
    applyStimulus("fwdImm", 0, 1, 1, 0, 0, 2'd1, 3'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd4, 5'd2, 2'd2, 2'd1, 32'h20);
    checkOutput("fwdImm.wdata", WriteDataM, 32'h20);
    checkOutput("fwdImm.result", ALUResultM, 32'h34);

    // beq taken and not taken, jump, and both together
    applyStimulus("beqTaken", 0, 0, 0, 1, 0, 2'd0, 3'd1, 32'd9, 32'd9, 32'h20, 32'h100, 32'h104, 5'd0, 2'd0, 2'd0, 32'd0);
    checkOutput("beqTaken.count", TakenCountM, 32'd1);
    applyStimulus("beqNot", 0, 0, 0, 1, 0, 2'd0, 3'd1, 32'd9, 32'd8, 32'h20, 32'h100, 32'h104, 5'd0, 2'd0, 2'd0, 32'd0);
    checkOutput("beqNot.count", TakenCountM, 32'd1);
    applyStimulus("jump", 1, 0, 0, 0, 1, 2'd2, 3'd0, 32'd1, 32'd2, 32'h40, 32'h40, 32'h44, 5'd1, 2'd0, 2'd0, 32'd0);
    checkOutput("jump.pc4", PCPlus4M, 32'h44);
    checkOutput("jump.count", TakenCountM, 32'd2);
    applyStimulus("brAndJump", 0, 0, 0, 1, 1, 2'd0, 3'd1, 32'd3, 32'd3, 32'h8, 32'h200, 32'h204, 5'd0, 2'd0, 2'd0, 32'd0);
    checkOutput("brAndJump.count", TakenCountM, 32'd3);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r1, r2;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      applyStimulus("rand", 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), ($urandom_range(0, 7) == 0),
                    2'($urandom), 3'($urandom), r1, r2, $urandom, $urandom,
                    $urandom, 5'($urandom), 2'($urandom), 2'($urandom), $urandom);
    end

    // Asynchronous reset pulse between edges during taken jumps
    for (int i = 0; i < 3; i++) begin
      applyStimulus("preRst", 1, 0, 0, 0, 1, 2'd0, 3'd0, 32'd7, 32'd1, 32'h10, 32'h300, 32'h304, 5'd4, 2'd0, 2'd0, 32'd0);
    end
    rst = 1'b1;
    modelReset();
    #1 checkRegs("asyncRst");
    #2 rst = 1'b0;
    applyStimulus("postRst", 1, 0, 0, 0, 1, 2'd0, 3'd0, 32'd7, 32'd1, 32'h10, 32'h300, 32'h304, 5'd4, 2'd0, 2'd0, 32'd0);
    checkOutput("postRst.count", TakenCountM, 32'd1);

    // Counter wrap from all-ones
    force dut.takenCount_q = 32'hFFFF_FFFE;
    #1 release dut.takenCount_q;
    mCount = 32'hFFFF_FFFE;
    applyStimulus("wrapA", 0, 0, 0, 0, 1, 2'd0, 3'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd4, 5'd0, 2'd0, 2'd0, 32'd0);
    checkOutput("wrapA.count", TakenCountM, 32'hFFFF_FFFF);
    applyStimulus("wrapB", 0, 0, 0, 0, 1, 2'd0, 3'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd4, 5'd0, 2'd0, 2'd0, 32'd0);
    checkOutput("wrapB.count", TakenCountM, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
